// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Multi-cycle data-memory responder sitting at the memory end of the
//   datapath's load/store interface. One read or write is accepted per
//   transaction, LATENCY wait states are inserted, then a single-cycle ready
//   pulse returns the load data (or flags an error). Byte, half and word
//   accesses are supported, little-endian, with alignment checking and
//   sign/zero extension of loads.
//
// Parameters
//   DATA_W       data width (four byte lanes, fixed at 32)
//   DM_ADDRESS   byte-address width; 2**(DM_ADDRESS-2) words of storage
//   LATENCY      wait cycles per access, 1..15
//
// Ports
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset (memory array not cleared)
//   mem_read_i     load request
//   mem_write_i    store request
//   addr_i         byte address
//   size_i         00 byte, 01 half, 10 word, 11 illegal
//   sign_ext_i     loads: 1 sign-extend, 0 zero-extend
//   write_data_i   right-justified store data
//   read_data_o    load result, zero unless ready_o
//   ready_o        one-cycle completion pulse
//   busy_o         transaction in progress, requests ignored
//   err_o          completion with error, zero unless ready_o
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int LATENCY    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic [DM_ADDRESS-1:0] addr_i,
  input  logic [1:0]            size_i,
  input  logic                  sign_ext_i,
  input  logic [DATA_W-1:0]     write_data_i,
  output logic [DATA_W-1:0]     read_data_o,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int         WORDS    = 2 ** (DM_ADDRESS - 2);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;

  logic [DM_ADDRESS-1:0]   addr_q;
  logic [1:0]              size_q;
  logic                    signExt_q;
  logic [DATA_W-1:0]       wdata_q;
  logic                    isWrite_q;
  logic                    errFlag_q;
  logic [DATA_W-1:0]       rdata_q;

  logic [DATA_W-1:0]       mem [WORDS];

  logic                    request;
  logic                    reqError;
  logic                    accept;
  logic                    finish;
  logic [DM_ADDRESS-3:0]   wordIdx;
  logic [1:0]              laneSel;
  logic [DATA_W-1:0]       memWord;
  logic [3:0]              byteMask;
  logic [DATA_W-1:0]       shiftedData;
  logic [DATA_W-1:0]       mergedWord;
  logic [DATA_W-1:0]       rawLoad;
  logic [DATA_W-1:0]       loadValue;

  assign request = mem_read_i | mem_write_i;
  assign accept  = (state_q == IDLE) && request;
  // The access itself happens on the last wait edge.
  assign finish  = (state_q == WAIT) && (cnt_q == 4'd0);

  // Request error classification, evaluated on the live inputs at accept.
  always_comb begin
    reqError = 1'b0;
    if (mem_read_i && mem_write_i) reqError = 1'b1;
    unique case (size_i)
      2'b01:   if (addr_i[0])          reqError = 1'b1;
      2'b10:   if (addr_i[1:0] != 2'b00) reqError = 1'b1;
      2'b11:   reqError = 1'b1;
      default: ;
    endcase
  end

  // State register and wait counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: errors skip straight to the response cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (request) begin
          if (reqError) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are gated by the response state so nothing leaks outside ready.
  always_comb begin
    ready_o     = (state_q == RESP);
    busy_o      = (state_q != IDLE);
    err_o       = ready_o && errFlag_q;
    read_data_o = (ready_o && !errFlag_q && !isWrite_q) ? rdata_q : '0;
  end

  // Request capture: only the latched copies drive the access afterwards.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q    <= '0;
      size_q    <= 2'b00;
      signExt_q <= 1'b0;
      wdata_q   <= '0;
      isWrite_q <= 1'b0;
      errFlag_q <= 1'b0;
    end else if (accept) begin
      addr_q    <= addr_i;
      size_q    <= size_i;
      signExt_q <= sign_ext_i;
      wdata_q   <= write_data_i;
      isWrite_q <= mem_write_i;
      errFlag_q <= reqError;
    end
  end

  assign wordIdx = addr_q[DM_ADDRESS-1:2];
  assign laneSel = addr_q[1:0];
  assign memWord = mem[wordIdx];

  // Store lane steering: place right-justified data on the addressed lanes.
  always_comb begin
    byteMask    = 4'b0000;
    shiftedData = '0;
    unique case (size_q)
      2'b00: begin
        byteMask    = 4'b0001 << laneSel;
        shiftedData = {{(DATA_W-8){1'b0}}, wdata_q[7:0]} << {laneSel, 3'b000};
      end
      2'b01: begin
        byteMask    = 4'b0011 << {laneSel[1], 1'b0};
        shiftedData = {{(DATA_W-16){1'b0}}, wdata_q[15:0]} << {laneSel[1], 4'b0000};
      end
      2'b10: begin
        byteMask    = 4'b1111;
        shiftedData = wdata_q;
      end
      default: ;
    endcase
    for (int b = 0; b < 4; b++) begin
      mergedWord[8*b +: 8] = byteMask[b] ? shiftedData[8*b +: 8] : memWord[8*b +: 8];
    end
  end

  // Load lane extraction: right-justify the addressed lanes, then extend.
  always_comb begin
    rawLoad   = '0;
    loadValue = '0;
    unique case (size_q)
      2'b00: begin
        rawLoad   = memWord >> {laneSel, 3'b000};
        loadValue = {{(DATA_W-8){signExt_q & rawLoad[7]}}, rawLoad[7:0]};
      end
      2'b01: begin
        rawLoad   = memWord >> {laneSel[1], 4'b0000};
        loadValue = {{(DATA_W-16){signExt_q & rawLoad[15]}}, rawLoad[15:0]};
      end
      2'b10: begin
        rawLoad   = memWord;
        loadValue = memWord;
      end
      default: ;
    endcase
  end

  // Load result register, captured on the access edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (finish) begin
      rdata_q <= loadValue;
    end
  end

  // Storage array has no reset; an aborted transaction never reaches finish.
  always_ff @(posedge clk_i) begin
    if (finish && isWrite_q) begin
      mem[wordIdx] <= mergedWord;
    end
  end

endmodule
